// File: rtl/dmem_port_arbiter_pkg.sv
// Shared constants for the data-memory port arbiter: read-owner codes and aging counter width.
package dmem_port_arbiter_pkg;

  localparam int          STARVE_CNT_W = 4;

  localparam logic [1:0]  OWN_NONE = 2'b00;
  localparam logic [1:0]  OWN_DMA  = 2'b01;
  localparam logic [1:0]  OWN_CPU  = 2'b10;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating aging counter for the DMA port; clear wins over increment, holds at LIMIT.
module arb_starve_counter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int LIMIT = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    inc,
  output logic [STARVE_CNT_W-1:0] cnt,
  output logic                    at_limit
);

  localparam logic [STARVE_CNT_W-1:0] LIM = STARVE_CNT_W'(LIMIT);

  logic [STARVE_CNT_W-1:0] cnt_q;
  logic [STARVE_CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LIM)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt      = cnt_q;
  assign at_limit = (cnt_q == LIM);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port data RAM between the CPU memory stage (priority) and a DMA
// requester, with an aging counter that forces a DMA grant and per-read return steering.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [3:0]        cpu_wea,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              dma_valid,
  output logic              dma_ready,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [3:0]        dma_wea,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wea,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic                    at_limit;
  logic                    force_dma;
  logic                    gnt_dma;
  logic                    gnt_cpu;
  logic [STARVE_CNT_W-1:0] starve_cnt;
  logic [1:0]              rd_own_q;
  logic [1:0]              rd_own_d;

  // Counter only ages while DMA is actually waiting.
  arb_starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (gnt_dma || !dma_valid),
    .inc      (1'b1),
    .cnt      (starve_cnt),
    .at_limit (at_limit)
  );

  always_comb begin
    force_dma = at_limit && dma_valid;
    gnt_dma   = dma_valid && (force_dma || !cpu_req);
    gnt_cpu   = cpu_req && !gnt_dma;
  end

  always_comb begin
    mem_addr  = '0;
    mem_wea   = '0;
    mem_wdata = '0;
    if (gnt_dma) begin
      mem_addr  = dma_addr;
      mem_wea   = dma_wea;
      mem_wdata = dma_wdata;
    end else if (gnt_cpu) begin
      mem_addr  = cpu_addr;
      mem_wea   = cpu_wea;
      mem_wdata = cpu_wdata;
    end
  end

  always_comb begin
    rd_own_d = OWN_NONE;
    if (gnt_cpu && (cpu_wea == 4'b0000)) begin
      rd_own_d = OWN_CPU;
    end else if (gnt_dma && (dma_wea == 4'b0000)) begin
      rd_own_d = OWN_DMA;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_own_q <= OWN_NONE;
    end else begin
      rd_own_q <= rd_own_d;
    end
  end

  assign dma_ready  = gnt_dma;
  assign cpu_stall  = cpu_req && gnt_dma;
  assign mem_en     = gnt_cpu || gnt_dma;
  assign cpu_rdata  = mem_rdata;
  assign dma_rdata  = mem_rdata;
  assign cpu_rvalid = (rd_own_q == OWN_CPU);
  assign dma_rvalid = (rd_own_q == OWN_DMA);

  logic unused_cnt;
  assign unused_cnt = ^starve_cnt;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized and directed bench for dmem_port_arbiter; two instances (limit 8 and limit 1)
// are compared against a cycle-level reference of the arbitration rules and a RAM model.
module tb_dmem_port_arbiter;

  localparam int AW = 14;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_req;
  logic [AW-1:0] cpu_addr;
  logic [3:0]    cpu_wea;
  logic [DW-1:0] cpu_wdata;
  logic          dma_valid;
  logic [AW-1:0] dma_addr;
  logic [3:0]    dma_wea;
  logic [DW-1:0] dma_wdata;

  logic          cpu_stall, cpu_rvalid, dma_ready, dma_rvalid, mem_en;
  logic [DW-1:0] cpu_rdata, dma_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_wea;

  logic          cpu_stall_1, cpu_rvalid_1, dma_ready_1, dma_rvalid_1, mem_en_1;
  logic [DW-1:0] cpu_rdata_1, dma_rdata_1, mem_wdata_1;
  logic [AW-1:0] mem_addr_1;
  logic [3:0]    mem_wea_1;

  logic [DW-1:0] ram_rdata;
  logic [DW-1:0] ram     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  int n_checks = 0;
  int n_errors = 0;

  int lim   [2] = '{8, 1};
  int lost  [2];
  bit erv_c [2];
  bit erv_d [2];
  logic [DW-1:0] edat_c, edat_d;
  bit last_gd, last_gd1, last_stall;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wea(cpu_wea), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .dma_valid(dma_valid), .dma_ready(dma_ready), .dma_addr(dma_addr), .dma_wea(dma_wea),
    .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_wea(mem_wea), .mem_wdata(mem_wdata),
    .mem_rdata(ram_rdata)
  );

  dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wea(cpu_wea), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall_1), .cpu_rdata(cpu_rdata_1), .cpu_rvalid(cpu_rvalid_1),
    .dma_valid(dma_valid), .dma_ready(dma_ready_1), .dma_addr(dma_addr), .dma_wea(dma_wea),
    .dma_wdata(dma_wdata), .dma_rdata(dma_rdata_1), .dma_rvalid(dma_rvalid_1),
    .mem_en(mem_en_1), .mem_addr(mem_addr_1), .mem_wea(mem_wea_1), .mem_wdata(mem_wdata_1),
    .mem_rdata(ram_rdata)
  );

  // RAM behind the limit-8 instance: 1-cycle registered read, byte-masked write.
  always @(posedge clk) begin
    if (mem_en) begin
      ram_rdata <= ram[mem_addr];
      for (int b = 0; b < 4; b++) begin
        if (mem_wea[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  function automatic logic [DW-1:0] pat(int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: check combinational and registered outputs at the negedge, then
  // advance the reference at the posedge. Inputs must already be applied by the caller.
  task automatic cycle();
    bit            f, gd [2], gc [2];
    logic [AW-1:0] ea;
    logic [3:0]    ew;
    logic [DW-1:0] ed;
    @(negedge clk);
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        lost[k] = 0; erv_c[k] = 0; erv_d[k] = 0;
      end
    end
    for (int k = 0; k < 2; k++) begin
      f     = dma_valid && (lost[k] >= lim[k]);
      gd[k] = dma_valid && (f || !cpu_req);
      gc[k] = cpu_req && !gd[k];
    end
    for (int k = 0; k < 2; k++) begin
      ea = gd[k] ? dma_addr  : gc[k] ? cpu_addr  : '0;
      ew = gd[k] ? dma_wea   : gc[k] ? cpu_wea   : '0;
      ed = gd[k] ? dma_wdata : gc[k] ? cpu_wdata : '0;
      if (k == 0) begin
        chk("dma_ready", 32'(dma_ready), 32'(gd[0]));
        chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req && gd[0]));
        chk("mem_en",    32'(mem_en),    32'(gd[0] || gc[0]));
        chk("mem_addr",  32'(mem_addr),  32'(ea));
        chk("mem_wea",   32'(mem_wea),   32'(ew));
        chk("mem_wdata", mem_wdata, ed);
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(erv_c[0]));
        chk("dma_rvalid", 32'(dma_rvalid), 32'(erv_d[0]));
        if (erv_c[0]) chk("cpu_rdata", cpu_rdata, edat_c);
        if (erv_d[0]) chk("dma_rdata", dma_rdata, edat_d);
      end else begin
        chk("l1_dma_ready", 32'(dma_ready_1), 32'(gd[1]));
        chk("l1_cpu_stall", 32'(cpu_stall_1), 32'(cpu_req && gd[1]));
        chk("l1_mem_en",    32'(mem_en_1),    32'(gd[1] || gc[1]));
        chk("l1_mem_addr",  32'(mem_addr_1),  32'(ea));
        chk("l1_mem_wea",   32'(mem_wea_1),   32'(ew));
        chk("l1_mem_wdata", mem_wdata_1, ed);
        chk("l1_cpu_rvalid", 32'(cpu_rvalid_1), 32'(erv_c[1]));
        chk("l1_dma_rvalid", 32'(dma_rvalid_1), 32'(erv_d[1]));
      end
    end
    last_gd    = gd[0];
    last_gd1   = gd[1];
    last_stall = cpu_req && gd[0];
    @(posedge clk);
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        erv_c[k] = gc[k] && (cpu_wea == 4'b0);
        erv_d[k] = gd[k] && (dma_wea == 4'b0);
        if (gd[k] || !dma_valid) lost[k] = 0;
        else if (lost[k] < lim[k]) lost[k]++;
      end
      if (gc[0] || gd[0]) begin
        ea = gd[0] ? dma_addr  : cpu_addr;
        ew = gd[0] ? dma_wea   : cpu_wea;
        ed = gd[0] ? dma_wdata : cpu_wdata;
        if (gc[0]) edat_c = ref_mem[ea];
        if (gd[0]) edat_d = ref_mem[ea];
        for (int b = 0; b < 4; b++) begin
          if (ew[b]) ref_mem[ea][8*b +: 8] = ed[8*b +: 8];
        end
      end
    end
    #1;
  endtask

  task automatic idle();
    cpu_req = 1'b0; cpu_addr = '0; cpu_wea = '0; cpu_wdata = '0;
    dma_valid = 1'b0; dma_addr = '0; dma_wea = '0; dma_wdata = '0;
  endtask

  task automatic set_cpu(input bit r, input int a, input logic [3:0] w, input logic [DW-1:0] d);
    cpu_req = r; cpu_addr = AW'(a); cpu_wea = w; cpu_wdata = d;
  endtask

  task automatic set_dma(input bit v, input int a, input logic [3:0] w, input logic [DW-1:0] d);
    dma_valid = v; dma_addr = AW'(a); dma_wea = w; dma_wdata = d;
  endtask

  function automatic logic [3:0] rnd_wea();
    case ($urandom_range(0, 3))
      0, 1:    return 4'h0;
      2:       return 4'hF;
      default: return 4'($urandom);
    endcase
  endfunction

  initial begin
    int wins;
    bit seen;
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]     = pat(i);
      ref_mem[i] = pat(i);
    end
    for (int k = 0; k < 2; k++) begin
      lost[k] = 0; erv_c[k] = 0; erv_d[k] = 0;
    end
    edat_c = '0; edat_d = '0;
    idle();
    rst_n = 1'b0;
    #1;
    chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("rst_dma_rvalid", 32'(dma_rvalid), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    cycle();
    cycle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // CPU-only read
    set_cpu(1, 'h010, 4'h0, '0);
    cycle();
    chk("t1_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("t1_cpu_rdata", cpu_rdata, pat('h010));
    chk("t1_dma_rvalid", 32'(dma_rvalid), 32'd0);
    idle();

    // DMA-only write then read back
    set_dma(1, 'h020, 4'hF, 32'hDEADBEEF);
    cycle();
    chk("t2_dma_ready", 32'(last_gd), 32'd1);
    set_dma(1, 'h020, 4'h0, '0);
    cycle();
    chk("t2_dma_rvalid", 32'(dma_rvalid), 32'd1);
    chk("t2_dma_rdata", dma_rdata, 32'hDEADBEEF);
    idle();
    cycle();

    // Continuous contention: period 9 for limit 8, alternation for limit 1
    set_cpu(1, 'h100, 4'h0, '0);
    set_dma(1, 'h200, 4'h0, '0);
    for (int k = 0; k < 27; k++) begin
      cycle();
      chk("t3_gnt_pattern", 32'(last_gd), 32'(k % 9 == 8));
      chk("t3_l1_alternate", 32'(last_gd1), 32'(k % 2 == 1));
    end
    idle();
    cycle();

    // Colliding writes to the same word at the limit
    set_cpu(1, 'h030, 4'hF, 32'h11111111);
    set_dma(1, 'h030, 4'hF, 32'h22222222);
    for (int k = 0; k < 10; k++) begin
      if (k == 9) set_dma(0, 0, 4'h0, '0);
      cycle();
      if (k == 8) chk("t4_dma_wins_c9", 32'(last_gd), 32'd1);
      if (k == 9) chk("t4_cpu_wins_c10", 32'(last_stall), 32'd0);
    end
    set_cpu(1, 'h030, 4'h0, '0);
    cycle();
    chk("t4_final_ram", cpu_rdata, 32'h11111111);
    idle();

    // Back-to-back reads to different owners
    set_cpu(1, 'h040, 4'h0, '0);
    cycle();
    chk("t5_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("t5_cpu_rdata", cpu_rdata, pat('h040));
    idle();
    set_dma(1, 'h050, 4'h0, '0);
    cycle();
    chk("t5_dma_rvalid", 32'(dma_rvalid), 32'd1);
    chk("t5_dma_rdata", dma_rdata, pat('h050));
    chk("t5_cpu_rvalid_off", 32'(cpu_rvalid), 32'd0);
    idle();

    // Reset while a read return is pending, with DMA partly aged
    set_cpu(1, 'h060, 4'h0, '0);
    set_dma(1, 'h070, 4'h0, '0);
    cycle();
    cycle();
    idle();
    rst_n = 1'b0;
    #1;
    chk("t6_rvalid_dropped", 32'(cpu_rvalid), 32'd0);
    cycle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    set_cpu(1, 'h080, 4'h0, '0);
    set_dma(1, 'h090, 4'h0, '0);
    wins = 0;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      cycle();
      if (last_gd) seen = 1;
      else wins++;
    end
    chk("t6_forced_seen", 32'(seen), 32'd1);
    chk("t6_cpu_wins", 32'(wins), 32'd8);
    idle();
    cycle();

    // Randomized traffic obeying the hold rules of both requesters
    for (int n = 0; n < 3000; n++) begin
      if (!(cpu_req && last_stall)) begin
        set_cpu($urandom_range(0, 3) != 0, $urandom_range(0, 63), rnd_wea(), $urandom);
      end
      if (!(dma_valid && !last_gd)) begin
        set_dma($urandom_range(0, 2) != 0, $urandom_range(0, 63), rnd_wea(), $urandom);
      end
      cycle();
    end
    idle();
    cycle();
    cycle();

    for (int i = 0; i < 64; i++) chk("ram_final", ram[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
